blit_cmpinh: RTL and testbench

- Pixel-compare and write-inhibit stage of the blitter data path; sits directly upstream of the blitter stop logic.
- Takes one 64-bit phrase per transaction from the data/Z pipeline and compares pixels against the pattern register (data compare) and source Z against destination Z (Z compare).
- Produces per-byte write enables for the write unit.
- In collision-stop mode, it drives nowrite and a collision pulse to the stop block and freezes while the stop block reports stopped.

---
 rtl/blit_cmpinh_pkg.sv | 36 +++
 rtl/blit_pixcmp.sv | 59 +++++
 rtl/blit_cmpinh.sv | 124 ++++++++++++
 tb/tb_blit_cmpinh.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blit_cmpinh_pkg.sv
// Shared blitter definitions: pixel-size codes, Z-mode bit positions,
// phrase geometry and the stage-1 pipeline payload.
package blit_cmpinh_pkg;

    localparam int PHW   = 64;
    localparam int NBYTE = PHW / 8;

    localparam logic [2:0] PIX8  = 3'd3;
    localparam logic [2:0] PIX16 = 3'd4;
    localparam logic [2:0] PIX32 = 3'd5;

    localparam int ZLT = 0;
    localparam int ZEQ = 1;
    localparam int ZGT = 2;

    // Internal pixel width class; unknown pixsize codes fall back to 16bpp.
    typedef enum logic [1:0] {PS_8, PS_16, PS_32} pixw_e;

    function automatic pixw_e decode_pix(input logic [2:0] ps);
        case (ps)
            PIX8:    return PS_8;
            PIX32:   return PS_32;
            default: return PS_16;
        endcase
    endfunction

    // Everything stage 2 needs about a phrase, captured at stage-1 time so
    // later config changes never affect a phrase already in flight.
    typedef struct packed {
        logic [NBYTE-1:0] pinh;
        logic [NBYTE-1:0] emask;
        pixw_e            pixw;
        logic             colstop;
    } s1_t;

endpackage

// File: rtl/blit_pixcmp.sv
// Combinational per-phrase pixel compare: data-vs-pattern and source-vs-
// destination Z, expanded to a per-byte inhibit vector.
module blit_pixcmp
    import blit_cmpinh_pkg::*;
(
    input  logic [PHW-1:0]   srcd,
    input  logic [PHW-1:0]   dstd,
    input  logic [PHW-1:0]   patd,
    input  logic [PHW-1:0]   srcz,
    input  logic [PHW-1:0]   dstz,
    input  pixw_e            pixw,
    input  logic             dcompen,
    input  logic             cmpdst,
    input  logic [2:0]       zmode,
    output logic [NBYTE-1:0] pinh
);

    logic [PHW-1:0] op;
    logic [7:0]     eq8;
    logic [3:0]     eq16;
    logic [3:0]     zinh;
    logic [1:0]     eq32;
    logic [7:0]     dinh;
    logic [7:0]     zexp;

    assign op = cmpdst ? dstd : srcd;

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_b8
            assign eq8[g] = (op[8*g +: 8] == patd[8*g +: 8]);
        end
        for (g = 0; g < 4; g++) begin : g_b16
            logic [15:0] za, zb;
            assign za       = srcz[16*g +: 16];
            assign zb       = dstz[16*g +: 16];
            assign eq16[g]  = (op[16*g +: 16] == patd[16*g +: 16]);
            assign zinh[g]  = ((za <  zb) && zmode[ZLT]) ||
                              ((za == zb) && zmode[ZEQ]) ||
                              ((za >  zb) && zmode[ZGT]);
        end
        for (g = 0; g < 2; g++) begin : g_b32
            assign eq32[g] = (op[32*g +: 32] == patd[32*g +: 32]);
        end
    endgenerate

    // Spread pixel-level results over the bytes each pixel occupies.
    always_comb begin
        dinh = '0;
        case (pixw)
            PS_8:    dinh = eq8;
            PS_32:   dinh = {{4{eq32[1]}}, {4{eq32[0]}}};
            default: dinh = {{2{eq16[3]}}, {2{eq16[2]}}, {2{eq16[1]}}, {2{eq16[0]}}};
        endcase
        zexp = {{2{zinh[3]}}, {2{zinh[2]}}, {2{zinh[1]}}, {2{zinh[0]}}};
        pinh = (dcompen ? dinh : 8'h00) | ((pixw == PS_16) ? zexp : 8'h00);
    end

endmodule

// File: rtl/blit_cmpinh.sv
// Blitter compare/write-inhibit stage: two-stage valid/ready pipeline that
// turns compare results into byte write enables, flags collisions to the
// stop block, freezes while stopped, and counts inhibited pixels.
module blit_cmpinh
    import blit_cmpinh_pkg::*;
#(
    parameter int CNTW = 16
) (
    input  logic             sys_clk,
    input  logic             xreset,
    input  logic             ph_valid,
    output logic             ph_ready,
    input  logic [PHW-1:0]   srcd,
    input  logic [PHW-1:0]   dstd,
    input  logic [PHW-1:0]   patd,
    input  logic [PHW-1:0]   srcz,
    input  logic [PHW-1:0]   dstz,
    input  logic [NBYTE-1:0] emask,
    input  logic [2:0]       pixsize,
    input  logic             dcompen,
    input  logic             cmpdst,
    input  logic [2:0]       zmode,
    input  logic             colstop_en,
    input  logic             stopped,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [NBYTE-1:0] wr_mask,
    output logic             nowrite,
    output logic             collide,
    output logic [CNTW-1:0]  inh_cnt,
    input  logic             cnt_clr
);

    pixw_e            pixw_c;
    logic [NBYTE-1:0] pinh_c;
    logic             s1_vld;
    s1_t              s1;
    logic             s1_adv, s2_adv, s2_load;
    logic [NBYTE-1:0] hit_b;
    logic             ihit, coll;
    logic [3:0]       pcnt;
    logic [CNTW:0]    cnt_sum;
    logic [CNTW-1:0]  cnt_nxt;

    assign pixw_c = decode_pix(pixsize);

    blit_pixcmp u_pixcmp (
        .srcd    (srcd),
        .dstd    (dstd),
        .patd    (patd),
        .srcz    (srcz),
        .dstz    (dstz),
        .pixw    (pixw_c),
        .dcompen (dcompen),
        .cmpdst  (cmpdst),
        .zmode   (zmode),
        .pinh    (pinh_c)
    );

    // Handshake: stopped freezes both stages, including output consumption.
    assign s2_adv   = !stopped && (!wr_valid || wr_ready);
    assign s1_adv   = !stopped && (!s1_vld || s2_adv);
    assign s2_load  = s1_vld && s2_adv;
    assign ph_ready = !xreset && s1_adv;

    assign hit_b = s1.pinh & s1.emask;
    assign ihit  = |hit_b;
    assign coll  = s1.colstop && ihit;

    // Inhibited pixels inside the span; a multi-byte pixel counts once.
    always_comb begin
        pcnt = '0;
        case (s1.pixw)
            PS_8:    for (int i = 0; i < 8; i++) pcnt = pcnt + 4'(hit_b[i]);
            PS_32:   pcnt = 4'(|hit_b[3:0]) + 4'(|hit_b[7:4]);
            default: for (int l = 0; l < 4; l++) pcnt = pcnt + 4'(|hit_b[2*l +: 2]);
        endcase
        cnt_sum = {1'b0, inh_cnt} + (CNTW+1)'(pcnt);
        cnt_nxt = cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];
    end

    // Stage 1: capture compare result and the config it depends on.
    always_ff @(posedge sys_clk) begin
        if (xreset) begin
            s1_vld <= 1'b0;
            s1     <= '0;
        end else if (s1_adv) begin
            s1_vld <= ph_valid;
            if (ph_valid)
                s1 <= '{pinh: pinh_c, emask: emask, pixw: pixw_c, colstop: colstop_en};
        end
    end

    // Stage 2: final mask, collision suppression and one-cycle collide pulse.
    always_ff @(posedge sys_clk) begin
        if (xreset) begin
            wr_valid <= 1'b0;
            wr_mask  <= '0;
            nowrite  <= 1'b0;
            collide  <= 1'b0;
        end else begin
            collide <= 1'b0;
            if (s2_load) begin
                wr_valid <= 1'b1;
                wr_mask  <= coll ? '0 : (s1.emask & ~s1.pinh);
                nowrite  <= coll;
                collide  <= coll;
            end else if (s2_adv) begin
                wr_valid <= 1'b0;
            end
        end
    end

    // Saturating inhibited-pixel counter; clear wins over a same-cycle load.
    always_ff @(posedge sys_clk) begin
        if (xreset)
            inh_cnt <= '0;
        else if (cnt_clr)
            inh_cnt <= '0;
        else if (s2_load)
            inh_cnt <= cnt_nxt;
    end

endmodule

// File: tb/tb_blit_cmpinh.sv
// Bench for blit_cmpinh: directed scenarios plus a randomized phase, all
// outputs checked against a pixel-level reference model and a scoreboard.
module tb_blit_cmpinh;

    logic        sys_clk = 1'b0;
    logic        xreset, ph_valid, ph_ready;
    logic [63:0] srcd, dstd, patd, srcz, dstz;
    logic [7:0]  emask;
    logic [2:0]  pixsize, zmode;
    logic        dcompen, cmpdst, colstop_en, stopped;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_mask;
    logic        nowrite, collide, cnt_clr;
    logic [15:0] inh_cnt;

    always #5 sys_clk = ~sys_clk;

    blit_cmpinh #(.CNTW(16)) dut (
        .sys_clk(sys_clk), .xreset(xreset), .ph_valid(ph_valid), .ph_ready(ph_ready),
        .srcd(srcd), .dstd(dstd), .patd(patd), .srcz(srcz), .dstz(dstz),
        .emask(emask), .pixsize(pixsize), .dcompen(dcompen), .cmpdst(cmpdst),
        .zmode(zmode), .colstop_en(colstop_en), .stopped(stopped),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_mask(wr_mask),
        .nowrite(nowrite), .collide(collide), .inh_cnt(inh_cnt), .cnt_clr(cnt_clr)
    );

    typedef struct {
        logic [7:0] mask;
        logic       nw;
        int         cnt;
        bit         col;
        int         adv;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;
    int   exp_cnt = 0, exp_col = 0, col_seen = 0, acc = 0;
    bit   fired;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: walk pixels of the configured width with plain arithmetic.
    function automatic exp_t model();
        exp_t        e;
        int          bpp, nb, np;
        logic [63:0] op, pm, a, b, za, zb;
        logic [7:0]  inh;
        bit          pi;
        bpp = (pixsize == 3) ? 8 : (pixsize == 5) ? 32 : 16;
        nb  = bpp / 8;
        np  = 8 / nb;
        op  = cmpdst ? dstd : srcd;
        pm  = (64'd1 << bpp) - 64'd1;
        inh = 0;
        e.cnt = 0;
        for (int p = 0; p < np; p++) begin
            a  = (op   >> (p*bpp)) & pm;
            b  = (patd >> (p*bpp)) & pm;
            za = (srcz >> (p*16)) & 64'hFFFF;
            zb = (dstz >> (p*16)) & 64'hFFFF;
            pi = dcompen && (a == b);
            if (bpp == 16)
                pi = pi || (za < zb && zmode[0]) || (za == zb && zmode[1]) || (za > zb && zmode[2]);
            if (pi) begin
                for (int k = 0; k < nb; k++) inh[p*nb + k] = 1'b1;
                if (((emask >> (p*nb)) & 8'((1 << nb) - 1)) != 0) e.cnt++;
            end
        end
        e.col  = colstop_en && ((inh & emask) != 0);
        e.nw   = e.col;
        e.mask = e.col ? 8'h00 : (emask & ~inh);
        e.adv  = 0;
        return e;
    endfunction

    // One clock: check handshake and scoreboard in the settled half-cycle.
    task automatic step();
        exp_t e;
        bit   fin, fout;
        #1;
        chk("ph_ready", ph_ready, !xreset && !stopped && (q.size() < 2 || wr_ready));
        if (!xreset) chk("wr_valid", wr_valid, q.size() > 0 && q[0].adv > 0);
        fin  = ph_valid && ph_ready && !xreset;
        fout = wr_valid && wr_ready && !stopped && !xreset;
        if (collide) col_seen++;
        if (fout) begin
            if (q.size() == 0) chk("spurious_out", 1, 0);
            else begin
                e = q.pop_front();
                chk("wr_mask", wr_mask, e.mask);
                chk("nowrite", nowrite, e.nw);
            end
        end
        if (!xreset && !stopped) foreach (q[i]) q[i].adv++;
        if (fin) begin
            e = model();
            q.push_back(e);
            exp_cnt = (exp_cnt + e.cnt > 65535) ? 65535 : exp_cnt + e.cnt;
            if (e.col) exp_col++;
            acc++;
        end
        fired = fin;
        if (xreset) q.delete();
        @(negedge sys_clk);
    endtask

    task automatic drain();
        ph_valid = 0; wr_ready = 1; stopped = 0;
        for (int k = 0; k < 20 && q.size() > 0; k++) step();
        chk("drain_left", q.size(), 0);
    endtask

    task automatic cfg8(input logic [63:0] s);
        pixsize = 3'd3; dcompen = 1; cmpdst = 0; zmode = 0; emask = 8'hFF;
        srcd = s; patd = 0; dstd = 64'hFFFF_FFFF_FFFF_FFFF;
    endtask

    task automatic rand_phrase();
        logic [2:0] pc;
        srcd = {$urandom, $urandom}; dstd = {$urandom, $urandom};
        patd = $urandom_range(1, 0) ? srcd : dstd;
        for (int b = 0; b < 8; b++) if ($urandom_range(1, 0)) patd[8*b +: 8] ^= 8'h5A;
        for (int l = 0; l < 4; l++) begin
            srcz[16*l +: 16] = 16'($urandom_range(3, 0));
            dstz[16*l +: 16] = 16'($urandom_range(3, 0));
        end
        pc = 3'($urandom_range(6, 2));
        pixsize = pc; dcompen = 1'($urandom); cmpdst = 1'($urandom);
        zmode = 3'($urandom); emask = 8'($urandom); colstop_en = 1'($urandom);
    endtask

    initial begin
        xreset = 1; ph_valid = 0; wr_ready = 1; stopped = 0; cnt_clr = 0;
        srcd = 0; dstd = 0; patd = 0; srcz = 0; dstz = 0; emask = 0;
        pixsize = 3'd4; dcompen = 0; cmpdst = 0; zmode = 0; colstop_en = 0;
        @(negedge sys_clk);
        step(); step();
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_mask", wr_mask, 0);
        chk("rst_nowrite", nowrite, 0);
        chk("rst_collide", collide, 0);
        chk("rst_inh_cnt", inh_cnt, 0);
        xreset = 0;

        // 8bpp data compare: zero bytes 1,3,4,6 match the pattern
        cfg8(64'h1100_2200_0033_0044);
        ph_valid = 1; step(); ph_valid = 0; step();
        chk("t8_mask", wr_mask, 8'hA5);
        chk("t8_nowrite", nowrite, 0);
        drain();
        chk("t8_cnt", inh_cnt, 4);

        // 16bpp Z less-than: lanes 0 and 3 inhibited
        cfg8(0); pixsize = 3'd4; dcompen = 0; zmode = 3'b001;
        srcz = {16'd1, 16'd9, 16'd9, 16'd5}; dstz = {16'd2, 16'd3, 16'd9, 16'd7};
        ph_valid = 1; step(); ph_valid = 0; step();
        chk("tz_mask", wr_mask, 8'h3C);
        drain();
        chk("tz_cnt", inh_cnt, 6);

        // Same phrase in collision-stop mode, stop held for 5 cycles
        colstop_en = 1;
        ph_valid = 1; step(); ph_valid = 0; step();
        chk("col_pulse", collide, 1);
        chk("col_nowrite", nowrite, 1);
        chk("col_mask", wr_mask, 0);
        stopped = 1; colstop_en = 0; cfg8(64'h1100_2200_0033_0044); ph_valid = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stop_hold_valid", wr_valid, 1);
            chk("stop_collide_low", collide, 0);
        end
        stopped = 0;
        step(); ph_valid = 0;
        chk("post_stop_lat1", wr_valid, 0);
        step();
        chk("post_stop_lat2", wr_valid, 1);
        drain();
        chk("col_count", col_seen, exp_col);
        chk("col_cnt_total", inh_cnt, exp_cnt);

        // 6-phrase burst with 4 cycles of back-pressure
        begin
            int sent = 0;
            for (int k = 0; k < 40 && sent < 6; k++) begin
                rand_phrase(); colstop_en = 0;
                ph_valid = 1; wr_ready = !(k >= 2 && k < 6);
                step();
                if (fired) sent++;
            end
            chk("burst_sent", sent, 6);
        end
        drain();
        chk("burst_cnt", inh_cnt, exp_cnt);

        // Randomized traffic with random back-pressure and stops
        for (int k = 0; k < 400; k++) begin
            rand_phrase();
            ph_valid = 1'($urandom_range(3, 0) != 0);
            wr_ready = 1'($urandom_range(3, 0) != 0);
            stopped  = ($urandom_range(9, 0) == 0);
            step();
        end
        drain();
        chk("rand_cnt", inh_cnt, exp_cnt);
        chk("rand_col", col_seen, exp_col);

        // Saturation: clear, then pump fully-inhibited 8bpp phrases
        cnt_clr = 1; step(); cnt_clr = 0; exp_cnt = 0;
        chk("clr_cnt", inh_cnt, 0);
        cfg8(0); colstop_en = 0;
        acc = 0;
        ph_valid = 1;
        for (int k = 0; k < 20000 && acc < 8191; k++) step();
        ph_valid = 0;
        chk("pump_acc", acc, 8191);
        cfg8(64'h0101_0000_0000_0000);
        ph_valid = 1; step(); ph_valid = 0;
        drain();
        chk("sat_fffe", inh_cnt, 16'hFFFE);
        chk("sat_fffe_m", inh_cnt, exp_cnt);
        cfg8(64'h0101_0101_0000_0000);
        ph_valid = 1; step(); ph_valid = 0;
        drain();
        chk("sat_ffff", inh_cnt, 16'hFFFF);
        cfg8(0);
        ph_valid = 1; step(); ph_valid = 0;
        drain();
        chk("sat_hold", inh_cnt, 16'hFFFF);

        // Clear coinciding with the stage-2 load of an inhibiting phrase
        cfg8(64'h0101_0101_0000_0000);
        ph_valid = 1; step(); ph_valid = 0;
        cnt_clr = 1; step(); cnt_clr = 0; exp_cnt = 0;
        chk("clr_prio", inh_cnt, 0);
        drain();
        chk("clr_prio_after", inh_cnt, 0);

        // Reset with both stages full and a collision pending in stage 1
        cfg8(0); colstop_en = 1; wr_ready = 0;
        acc = 0; ph_valid = 1;
        for (int k = 0; k < 10 && acc < 2; k++) step();
        ph_valid = 0;
        chk("rst_fill", acc, 2);
        xreset = 1; step();
        chk("mrst_wr_valid", wr_valid, 0);
        chk("mrst_nowrite", nowrite, 0);
        chk("mrst_inh_cnt", inh_cnt, 0);
        chk("mrst_collide", collide, 0);
        step();
        xreset = 0; wr_ready = 1; exp_cnt = 0;
        step();
        chk("mrst_no_pulse", collide, 0);
        chk("mrst_idle", wr_valid, 0);
        chk("mrst_cnt", inh_cnt, exp_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
